wb_trace_checker: RTL and testbench

- Consumes the CPU's writeback trace debug interface (debug_wb_pc/rf_we/rf_wnum/rf_wdata) and compares each architectural register write against a golden trace stream.
- The golden stream is buffered in an internal FIFO.
- Reports pass on reaching END_PC, or fail with captured mismatch details.
- Sits beside the CPU top in the simulation/FPGA test harness.

---
 rtl/wb_trace_checker.sv | 216 +++++++++++++++++++++
 tb/tb_wb_trace_checker.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_checker.sv
// Writeback trace checker: compares each retired register write of the CPU
// against a buffered golden stream and latches pass/fail with mismatch details.
module wb_trace_checker #(
  parameter int          FIFO_DEPTH     = 8,
  parameter logic [31:0] END_PC         = 32'h1c00_0100,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chk_en,
  input  logic [31:0] debug_wb_pc,
  input  logic [3:0]  debug_wb_rf_we,
  input  logic [4:0]  debug_wb_rf_wnum,
  input  logic [31:0] debug_wb_rf_wdata,
  input  logic        gold_valid,
  output logic        gold_ready,
  input  logic [31:0] gold_pc,
  input  logic [4:0]  gold_wnum,
  input  logic [31:0] gold_wdata,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [2:0]  err_code,
  output logic [31:0] err_pc,
  output logic [31:0] err_exp_wdata,
  output logic [31:0] err_act_wdata,
  output logic [31:0] match_count,
  output logic [1:0]  dbg_state
);

  // Golden push: gold_valid & gold_ready on the rising clk edge.
  // gold_ready depends only on registered state, never on gold_valid.

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [31:0]   TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   mem_pc_q    [FIFO_DEPTH];
  logic [31:0]   mem_pc_d    [FIFO_DEPTH];
  logic [4:0]    mem_wnum_q  [FIFO_DEPTH];
  logic [4:0]    mem_wnum_d  [FIFO_DEPTH];
  logic [31:0]   mem_wdata_q [FIFO_DEPTH];
  logic [31:0]   mem_wdata_d [FIFO_DEPTH];

  logic [31:0] tmo_q, tmo_d;
  logic [31:0] match_q, match_d;
  logic [2:0]  err_code_q, err_code_d;
  logic [31:0] err_pc_q, err_pc_d;
  logic [31:0] err_exp_q, err_exp_d;
  logic [31:0] err_act_q, err_act_d;

  logic        in_run, is_done, empty, full;
  logic        push, pop, evt;
  logic [31:0] head_pc, head_wdata;
  logic [4:0]  head_wnum;
  logic        fail_now, is_match, end_hit;
  logic [2:0]  fail_code;
  logic [31:0] fail_exp, fail_act;

  assign in_run     = (state_q == ST_RUN);
  assign is_done    = (state_q == ST_PASS) || (state_q == ST_FAIL);
  assign empty      = (cnt_q == '0);
  assign full       = (cnt_q == FULL_CNT);
  assign gold_ready = ~full & ~is_done;
  assign push       = gold_valid & gold_ready;
  assign evt        = in_run & (|debug_wb_rf_we) & (debug_wb_rf_wnum != 5'd0);
  assign pop        = evt & ~empty;

  assign head_pc    = mem_pc_q[rd_ptr_q];
  assign head_wnum  = mem_wnum_q[rd_ptr_q];
  assign head_wdata = mem_wdata_q[rd_ptr_q];

  // Compare against the registered head only; this cycle's push is not visible.
  always_comb begin
    fail_now  = 1'b0;
    fail_code = 3'd0;
    fail_exp  = 32'd0;
    fail_act  = debug_wb_rf_wdata;
    is_match  = 1'b0;
    if (evt) begin
      if (empty) begin
        fail_now  = 1'b1;
        fail_code = 3'd3;
      end else if (head_pc != debug_wb_pc) begin
        fail_now  = 1'b1;
        fail_code = 3'd1;
        fail_exp  = head_wdata;
      end else if ((head_wnum != debug_wb_rf_wnum) || (head_wdata != debug_wb_rf_wdata)) begin
        fail_now  = 1'b1;
        fail_code = 3'd2;
        fail_exp  = head_wdata;
      end else begin
        is_match = 1'b1;
      end
    end else if (in_run && (tmo_q == TMO_LAST)) begin
      fail_now  = 1'b1;
      fail_code = 3'd4;
      fail_act  = 32'd0;
    end
  end

  assign end_hit = in_run & (debug_wb_pc == END_PC) & ~fail_now;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (chk_en) state_d = ST_RUN;
      ST_RUN: begin
        if (fail_now)     state_d = ST_FAIL;
        else if (end_hit) state_d = ST_PASS;
      end
      default: state_d = state_q;
    endcase
  end

  // FSM: outputs
  always_comb begin
    pass      = (state_q == ST_PASS);
    fail      = (state_q == ST_FAIL);
    done      = pass | fail;
    dbg_state = state_q;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q + CW'(push) - CW'(pop);
    mem_pc_d    = mem_pc_q;
    mem_wnum_d  = mem_wnum_q;
    mem_wdata_d = mem_wdata_q;
    if (push) begin
      mem_pc_d[wr_ptr_q]    = gold_pc;
      mem_wnum_d[wr_ptr_q]  = gold_wnum;
      mem_wdata_d[wr_ptr_q] = gold_wdata;
      wr_ptr_d              = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
  end

  always_comb begin
    tmo_d      = tmo_q;
    match_d    = match_q;
    err_code_d = err_code_q;
    err_pc_d   = err_pc_q;
    err_exp_d  = err_exp_q;
    err_act_d  = err_act_q;
    if ((state_q == ST_IDLE) && chk_en) tmo_d = 32'd0;
    else if (in_run)                    tmo_d = evt ? 32'd0 : tmo_q + 32'd1;
    if (is_match) match_d = match_q + 32'd1;
    // fail_now only fires in RUN, so this captures the first failure alone.
    if (fail_now) begin
      err_code_d = fail_code;
      err_pc_d   = debug_wb_pc;
      err_exp_d  = fail_exp;
      err_act_d  = fail_act;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      tmo_q      <= 32'd0;
      match_q    <= 32'd0;
      err_code_q <= 3'd0;
      err_pc_q   <= 32'd0;
      err_exp_q  <= 32'd0;
      err_act_q  <= 32'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      match_q    <= match_d;
      err_code_q <= err_code_d;
      err_pc_q   <= err_pc_d;
      err_exp_q  <= err_exp_d;
      err_act_q  <= err_act_d;
    end
  end

  // Storage holds no reset value; the count alone defines which entries are live.
  always_ff @(posedge clk) begin
    mem_pc_q    <= mem_pc_d;
    mem_wnum_q  <= mem_wnum_d;
    mem_wdata_q <= mem_wdata_d;
  end

  assign err_code      = err_code_q;
  assign err_pc        = err_pc_q;
  assign err_exp_wdata = err_exp_q;
  assign err_act_wdata = err_act_q;
  assign match_count   = match_q;

endmodule

// File: tb/tb_wb_trace_checker.sv
// Bench for wb_trace_checker: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the golden stream.
module tb_wb_trace_checker;

  localparam int          DEPTH = 8;
  localparam logic [31:0] ENDPC = 32'h1c00_0100;
  localparam int          TMO   = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        chk_en;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic        gold_valid;
  logic        gold_ready;
  logic [31:0] gold_pc;
  logic [4:0]  gold_wnum;
  logic [31:0] gold_wdata;
  logic        done, pass, fail;
  logic [2:0]  err_code;
  logic [31:0] err_pc, err_exp_wdata, err_act_wdata, match_count;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  wb_trace_checker #(.FIFO_DEPTH(DEPTH), .END_PC(ENDPC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .chk_en(chk_en),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .gold_valid(gold_valid), .gold_ready(gold_ready), .gold_pc(gold_pc),
    .gold_wnum(gold_wnum), .gold_wdata(gold_wdata), .done(done), .pass(pass),
    .fail(fail), .err_code(err_code), .err_pc(err_pc), .err_exp_wdata(err_exp_wdata),
    .err_act_wdata(err_act_wdata), .match_count(match_count), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: golden entries in a queue, outcome as plain variables.
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } gold_t;

  gold_t       m_q[$];
  int          m_phase;   // 0 waiting for chk_en, 1 checking, 2 passed, 3 failed
  int          m_idle_run;
  int          m_match;
  int          m_code;
  logic [31:0] m_pc, m_exp, m_act;

  function automatic void model_clear();
    m_q.delete();
    m_phase = 0; m_idle_run = 0; m_match = 0;
    m_code = 0; m_pc = 0; m_exp = 0; m_act = 0;
  endfunction

  function automatic void model_step();
    bit    accept, is_evt, failed;
    gold_t head;
    if (reset) begin
      model_clear();
      return;
    end
    accept = gold_valid && (m_q.size() < DEPTH) && (m_phase < 2);
    if (m_phase == 0) begin
      if (chk_en) begin m_phase = 1; m_idle_run = 0; end
    end else if (m_phase == 1) begin
      is_evt = (debug_wb_rf_we != 0) && (debug_wb_rf_wnum != 0);
      failed = 0;
      if (is_evt) begin
        m_idle_run = 0;
        if (m_q.size() == 0) begin
          failed = 1; m_code = 3; m_exp = 0; m_act = debug_wb_rf_wdata;
        end else begin
          head = m_q.pop_front();
          if (head.pc != debug_wb_pc) begin
            failed = 1; m_code = 1; m_exp = head.wdata; m_act = debug_wb_rf_wdata;
          end else if (head.wnum != debug_wb_rf_wnum || head.wdata != debug_wb_rf_wdata) begin
            failed = 1; m_code = 2; m_exp = head.wdata; m_act = debug_wb_rf_wdata;
          end else begin
            m_match++;
          end
        end
      end else begin
        m_idle_run++;
        if (m_idle_run == TMO) begin
          failed = 1; m_code = 4; m_exp = 0; m_act = 0;
        end
      end
      if (failed) begin
        m_phase = 3; m_pc = debug_wb_pc;
      end else if (debug_wb_pc == ENDPC) begin
        m_phase = 2;
      end
    end
    if (accept) m_q.push_back('{pc: gold_pc, wnum: gold_wnum, wdata: gold_wdata});
  endfunction

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    chk_en = 0; debug_wb_pc = 0; debug_wb_rf_we = 0; debug_wb_rf_wnum = 0;
    debug_wb_rf_wdata = 0; gold_valid = 0; gold_pc = 0; gold_wnum = 0; gold_wdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    cycle();
    cycle();
    reset = 0;
  endtask

  task automatic push_gold(input logic [31:0] pc, input logic [4:0] wn, input logic [31:0] wd);
    gold_valid = 1; gold_pc = pc; gold_wnum = wn; gold_wdata = wd;
    cycle();
    gold_valid = 0;
  endtask

  task automatic wb_event(input logic [31:0] pc, input logic [4:0] wn, input logic [31:0] wd);
    debug_wb_pc = pc; debug_wb_rf_we = 4'hf; debug_wb_rf_wnum = wn; debug_wb_rf_wdata = wd;
    cycle();
    debug_wb_pc = 0; debug_wb_rf_we = 0; debug_wb_rf_wnum = 0; debug_wb_rf_wdata = 0;
  endtask

  task automatic start_run();
    chk_en = 1;
    cycle();
    chk_en = 0;
  endtask

  task automatic prefill3();
    push_gold(32'h1c00_0000, 5'd4, 32'h10);
    push_gold(32'h1c00_0004, 5'd5, 32'h20);
    push_gold(32'h1c00_0008, 5'd6, 32'h30);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({done, pass, fail} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: done/pass/fail=%b want 000", {done, pass, fail});
    end
    checks++;
    if (err_code !== 3'd0 || err_pc !== 0 || err_exp_wdata !== 0 || err_act_wdata !== 0) begin
      errors++; $display("FAIL reset_err: code=%0d pc=%h exp=%h act=%h want all 0",
                         err_code, err_pc, err_exp_wdata, err_act_wdata);
    end
    checks++;
    if (match_count !== 0 || gold_ready !== 1'b1 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL reset_misc: match=%0d ready=%b state=%0d want 0/1/0",
                         match_count, gold_ready, dbg_state);
    end
  endtask

  task automatic test_pass();
    do_reset();
    prefill3();
    start_run();
    wb_event(32'h1c00_0000, 5'd4, 32'h10);
    wb_event(32'h1c00_0004, 5'd5, 32'h20);
    wb_event(32'h1c00_0008, 5'd6, 32'h30);
    debug_wb_pc = ENDPC;
    cycle();
    debug_wb_pc = 0;
    checks++;
    if ({done, pass, fail} !== 3'b110 || match_count !== 32'd3 || err_code !== 3'd0) begin
      errors++; $display("FAIL pass_end: done/pass/fail=%b match=%0d code=%0d want 110/3/0",
                         {done, pass, fail}, match_count, err_code);
    end
    wb_event(32'h1c00_0000, 5'd7, 32'h99);
    checks++;
    if (pass !== 1'b1 || match_count !== 32'd3 || fail !== 1'b0 || gold_ready !== 1'b0) begin
      errors++; $display("FAIL pass_sticky: pass=%b fail=%b match=%0d ready=%b want 1/0/3/0",
                         pass, fail, match_count, gold_ready);
    end
  endtask

  task automatic test_data_mismatch();
    do_reset();
    prefill3();
    start_run();
    wb_event(32'h1c00_0000, 5'd4, 32'h10);
    wb_event(32'h1c00_0004, 5'd5, 32'h20);
    checks++;
    if (fail !== 1'b0 || match_count !== 32'd2) begin
      errors++; $display("FAIL mism_pre: fail=%b match=%0d want 0/2", fail, match_count);
    end
    wb_event(32'h1c00_0008, 5'd6, 32'h31);
    checks++;
    if (fail !== 1'b1 || done !== 1'b1 || err_code !== 3'd2 || err_pc !== 32'h1c00_0008) begin
      errors++; $display("FAIL mism_code: fail=%b done=%b code=%0d pc=%h want 1/1/2/1c000008",
                         fail, done, err_code, err_pc);
    end
    checks++;
    if (err_exp_wdata !== 32'h30 || err_act_wdata !== 32'h31 || match_count !== 32'd2) begin
      errors++; $display("FAIL mism_data: exp=%h act=%h match=%0d want 30/31/2",
                         err_exp_wdata, err_act_wdata, match_count);
    end
  endtask

  task automatic test_r0_ignored();
    do_reset();
    push_gold(32'h1c00_0000, 5'd4, 32'h10);
    push_gold(32'h1c00_0004, 5'd5, 32'h20);
    start_run();
    for (int i = 0; i < 5; i++) wb_event(32'h1c00_0000, 5'd0, 32'h55);
    checks++;
    if (fail !== 1'b0 || match_count !== 32'd0 || dbg_state !== 2'd1) begin
      errors++; $display("FAIL r0_state: fail=%b match=%0d state=%0d want 0/0/1",
                         fail, match_count, dbg_state);
    end
    // Occupancy still 2: six more accepts must fill the FIFO exactly.
    for (int i = 0; i < 5; i++) push_gold(32'h2000_0000 + i, 5'd1, i);
    checks++;
    if (gold_ready !== 1'b1) begin
      errors++; $display("FAIL r0_count7: ready=%b want 1", gold_ready);
    end
    push_gold(32'h2000_0005, 5'd1, 5);
    checks++;
    if (gold_ready !== 1'b0) begin
      errors++; $display("FAIL r0_count8: ready=%b want 0", gold_ready);
    end
    wb_event(32'h1c00_0000, 5'd4, 32'h10);
    checks++;
    if (match_count !== 32'd1 || fail !== 1'b0) begin
      errors++; $display("FAIL r0_head: match=%0d fail=%b want 1/0", match_count, fail);
    end
  endtask

  task automatic test_underflow_no_bypass();
    do_reset();
    start_run();
    gold_valid = 1; gold_pc = 32'h1c00_0000; gold_wnum = 5'd3; gold_wdata = 32'habcd;
    wb_event(32'h1c00_0000, 5'd3, 32'habcd);
    gold_valid = 0;
    checks++;
    if (fail !== 1'b1 || err_code !== 3'd3 || err_pc !== 32'h1c00_0000) begin
      errors++; $display("FAIL uflow_code: fail=%b code=%0d pc=%h want 1/3/1c000000",
                         fail, err_code, err_pc);
    end
    checks++;
    if (err_exp_wdata !== 32'd0 || err_act_wdata !== 32'habcd || match_count !== 0) begin
      errors++; $display("FAIL uflow_data: exp=%h act=%h match=%0d want 0/abcd/0",
                         err_exp_wdata, err_act_wdata, match_count);
    end
  endtask

  task automatic test_fifo_full();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      gold_valid = 1; gold_pc = 32'h1c00_0000 + 32'(4 * i);
      gold_wnum = 5'(i + 1); gold_wdata = 32'h100 + 32'(i);
      checks++;
      if (gold_ready !== (i < 8)) begin
        errors++; $display("FAIL full_ready%0d: ready=%b want %b", i, gold_ready, (i < 8));
      end
      cycle();
    end
    checks++;
    if (gold_ready !== 1'b0) begin
      errors++; $display("FAIL full_held: ready=%b want 0", gold_ready);
    end
    start_run();
    debug_wb_pc = 32'h1c00_0000; debug_wb_rf_we = 4'h1;
    debug_wb_rf_wnum = 5'd1; debug_wb_rf_wdata = 32'h100;
    checks++;
    if (gold_ready !== 1'b0) begin
      errors++; $display("FAIL full_nobypass: ready=%b want 0", gold_ready);
    end
    cycle();
    debug_wb_rf_we = 0; debug_wb_pc = 0;
    checks++;
    if (gold_ready !== 1'b1 || match_count !== 32'd1) begin
      errors++; $display("FAIL full_after_pop: ready=%b match=%0d want 1/1", gold_ready, match_count);
    end
    cycle();
    gold_valid = 0;
    checks++;
    if (gold_ready !== 1'b0) begin
      errors++; $display("FAIL full_refill: ready=%b want 0", gold_ready);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    start_run();
    for (int i = 0; i < TMO - 1; i++) cycle();
    checks++;
    if (fail !== 1'b0) begin
      errors++; $display("FAIL tmo_early: fail=%b after %0d idle cycles want 0", fail, TMO - 1);
    end
    cycle();
    checks++;
    if (fail !== 1'b1 || err_code !== 3'd4 || err_exp_wdata !== 0 || err_act_wdata !== 0) begin
      errors++; $display("FAIL tmo_fire: fail=%b code=%0d exp=%h act=%h want 1/4/0/0",
                         fail, err_code, err_exp_wdata, err_act_wdata);
    end
    do_reset();
    push_gold(32'h1c00_0000, 5'd2, 32'h1);
    start_run();
    for (int i = 0; i < 10; i++) cycle();
    reset = 1;
    cycle();
    reset = 0;
    checks++;
    if (fail !== 1'b0 || dbg_state !== 2'd0 || gold_ready !== 1'b1 || err_code !== 0) begin
      errors++; $display("FAIL tmo_reset: fail=%b state=%0d ready=%b code=%0d want 0/0/1/0",
                         fail, dbg_state, gold_ready, err_code);
    end
    start_run();
    wb_event(32'h1c00_0000, 5'd2, 32'h1);
    checks++;
    if (err_code !== 3'd3) begin
      errors++; $display("FAIL tmo_reset_empty: code=%0d want 3", err_code);
    end
  endtask

  task automatic test_random();
    int r;
    for (int it = 0; it < 8; it++) begin
      do_reset();
      r = $urandom_range(0, DEPTH);
      for (int k = 0; k < r; k++)
        push_gold(32'h1c00_0000 + 32'(4 * k), 5'($urandom_range(1, 31)), $urandom);
      chk_en = 1;
      for (int c = 0; c < 40; c++) begin
        gold_valid = $urandom_range(0, 1);
        gold_pc = 32'h1c00_0000 + 32'(4 * $urandom_range(0, 15));
        gold_wnum = 5'($urandom_range(0, 31));
        gold_wdata = $urandom;
        r = $urandom_range(0, 19);
        debug_wb_pc = 32'h1c00_0000 + 32'(4 * $urandom_range(0, 15));
        debug_wb_rf_we = 0; debug_wb_rf_wnum = 0; debug_wb_rf_wdata = $urandom;
        if (r < 12) begin
          debug_wb_rf_we = 4'($urandom_range(1, 15));
          debug_wb_rf_wnum = 5'($urandom_range(1, 31));
          if (m_q.size() > 0 && $urandom_range(0, 9) < 8) begin
            debug_wb_pc = m_q[0].pc; debug_wb_rf_wnum = m_q[0].wnum;
            debug_wb_rf_wdata = m_q[0].wdata;
            if (r == 11) debug_wb_pc = ENDPC;
          end
        end else if (r < 14) begin
          debug_wb_rf_we = 4'hf;
        end else if (r == 14) begin
          debug_wb_pc = ENDPC;
        end
        cycle();
        chk_en = $urandom_range(0, 1);
        checks++;
        if (done !== (m_phase >= 2) || pass !== (m_phase == 2) || fail !== (m_phase == 3)) begin
          errors++; $display("FAIL rnd_flags it%0d c%0d: d/p/f=%b%b%b want phase %0d",
                             it, c, done, pass, fail, m_phase);
        end
        checks++;
        if (err_code !== 3'(m_code) || err_pc !== m_pc || err_exp_wdata !== m_exp || err_act_wdata !== m_act) begin
          errors++; $display("FAIL rnd_err it%0d c%0d: code=%0d pc=%h exp=%h act=%h want %0d/%h/%h/%h",
                             it, c, err_code, err_pc, err_exp_wdata, err_act_wdata, m_code, m_pc, m_exp, m_act);
        end
        checks++;
        if (match_count !== 32'(m_match) || gold_ready !== ((m_q.size() < DEPTH) && (m_phase < 2))) begin
          errors++; $display("FAIL rnd_cnt it%0d c%0d: match=%0d ready=%b want %0d/%b",
                             it, c, match_count, gold_ready, m_match,
                             (m_q.size() < DEPTH) && (m_phase < 2));
        end
      end
      idle_inputs();
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    model_clear();
    test_reset();
    test_pass();
    test_data_mismatch();
    test_r0_ignored();
    test_underflow_no_bypass();
    test_fifo_full();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
